vid_timing_gen: RTL and testbench
=================================

Name: vid_timing_gen

Overview:
Synthesizable, parametrised video timing and test-pattern generator. It produces DE, HSYNC and VSYNC with configurable resolution, porches and sync polarity, plus 8-bit RGB from a selectable pattern. Frame and line markers and pixel coordinates are also output. It sits at the head of the video pipeline as the stimulus source for the processing IPs, on hardware and in simulation, with no file I/O.

Parameters:
H_RES, 64, active pixels per line
H_FP, 8, horizontal front porch (clocks)
H_SYNC, 2, horizontal sync width (clocks)
H_BP, 8, horizontal back porch (clocks)
V_RES, 64, active lines per frame
V_FP, 8, vertical front porch (lines)
V_SYNC, 4, vertical sync width (lines)
V_BP, 8, vertical back porch (lines)
HS_POL, 0, HSYNC active level (0 = active-low, as on Zybo)
VS_POL, 0, VSYNC active level
CHK_LOG2, 3, checker square size is 2^CHK_LOG2 pixels
SOLID_RGB, 24'h808080, colour for mode 0, as {r,g,b}

Ports:
clk  in  1  pixel clock
rst  in  1  asynchronous reset, active-high
en  in  1  run request, acted on only at frame boundaries
mode  in  2  pattern select: 0 solid, 1 colour bars, 2 ramp, 3 checker
hdmi_de  out  1  data enable
hdmi_hs  out  1  horizontal sync, polarity per HS_POL
hdmi_vs  out  1  vertical sync, polarity per VS_POL
hdmi_r  out  8  red
hdmi_g  out  8  green
hdmi_b  out  8  blue
pix_x  out  11  column of the current output pixel (valid when hdmi_de)
pix_y  out  11  row of the current output pixel (valid when hdmi_de)
frame_start  out  1  one-cycle pulse with the first pixel (x=0, y=0)
line_start  out  1  one-cycle pulse with x=0 of every active line

Behaviour:
- Definitions: H_TOT = H_RES+H_FP+H_SYNC+H_BP; V_TOT likewise. Internal counters are hc (0..H_TOT-1) and vc (0..V_TOT-1).
- Line order is active, front porch, sync, back porch. The frame uses the same order in lines.
- hc wraps to 0 after H_TOT-1. vc increments on that wrap and itself wraps to 0 after V_TOT-1.
- Sync is active for hc in [H_RES+H_FP, H_RES+H_FP+H_SYNC) and vc in [V_RES+V_FP, V_RES+V_FP+V_SYNC).
- VSYNC changes aligned to hc = 0.
- DE = (hc < H_RES) && (vc < V_RES).
- All outputs are registered, with a fixed latency of 1 clk from counter state to pins. DE, syncs, RGB, pix_x/y and the pulses stay mutually aligned.
- Reset (async):
  - counters 0, state IDLE;
  - hdmi_de = 0, syncs at inactive level (~HS_POL / ~VS_POL);
  - RGB = 0, pix_x/y = 0, pulses 0;
  - frame counter fcnt (8-bit) = 0.
- FSM has two states, IDLE and RUN:
  - IDLE: counters held at 0, outputs at their reset values. Go to RUN on the first clk with en = 1. The first output frame_start follows 1 clk later.
  - RUN: counters free-run. en is sampled only at the final count (hc = H_TOT-1, vc = V_TOT-1).
  - If en = 0 at that point: go to IDLE. The current frame always completes; no truncated frames.
  - If en = 1: continue, and fcnt increments by 1 (wraps at 255).
- mode is latched at frame start (entering RUN, or at the wrap to vc = 0, hc = 0) and is constant for the whole frame. Mid-frame changes are ignored.
- Patterns, with x/y the active pixel coordinates:
  - mode 0: SOLID_RGB.
  - mode 1: 8 equal vertical bars, H_RES a multiple of 8, bar k covering x in [k*H_RES/8, (k+1)*H_RES/8). Order is white, yellow, cyan, green, magenta, red, blue, black, with components 255 or 0. No divider: use a bar sub-counter.
  - mode 2: r = x[7:0], g = y[7:0], b = x[7:0] ^ y[7:0]; wraps naturally beyond 256.
  - mode 3: white when (x[CHK_LOG2] ^ y[CHK_LOG2] ^ fcnt[0]) = 1, else black. The phase inverts every frame.
- RGB = 0 whenever hdmi_de = 0, in every mode.
- Reset mid-frame: outputs return to reset values immediately (async). After release, the block restarts from IDLE.
- en toggling within a frame has no effect. Only the value at the final count matters.

Test Plan:
1. Defaults, en = 1, mode = 0, run 2 frames:
   - 82 clks per line, 84 lines per frame (6888 clks); 4096 DE cycles per frame;
   - hdmi_hs low for exactly 2 clks starting 72 clks after the line's first DE;
   - hdmi_vs low for 4 lines; RGB = 80/80/80 during DE.
2. mode = 1: on line 0, pixels 0-7 = FF/FF/FF, pixels 8-15 = FF/FF/00, …, pixels 56-63 = 00/00/00; RGB = 0 in blanking.
3. mode = 3, 2 frames: pixel (0,0) is black in frame 0 and white in frame 1; pixel (8,0) is the inverse of (0,0) within each frame.
4. Change mode 0→2 at line 10: frame stays solid to its end; the next frame at pixel (5,3) gives r = 05, g = 03, b = 06.
5. Drop en at line 20: the frame completes (full 4096 DE), then IDLE with DE = 0, syncs high and no frame_start. Re-raise en: frame_start 2 clks later.
6. Assert rst at mid-line, with pixel x = 30: same cycle DE = 0, RGB = 0, syncs high. After release with en = 1: a clean frame_start and a full-length first line.

Source files
------------

// File: rtl/vid_timing_gen.sv
// rtl/vid_timing_gen.sv - video timing and test-pattern generator
// Outputs are registered from the hc/vc counter state with one clock of latency.
module vid_timing_gen #(
  parameter int          H_RES     = 64,
  parameter int          H_FP      = 8,
  parameter int          H_SYNC    = 2,
  parameter int          H_BP      = 8,
  parameter int          V_RES     = 64,
  parameter int          V_FP      = 8,
  parameter int          V_SYNC    = 4,
  parameter int          V_BP      = 8,
  parameter logic        HS_POL    = 1'b0,
  parameter logic        VS_POL    = 1'b0,
  parameter int          CHK_LOG2  = 3,
  parameter logic [23:0] SOLID_RGB = 24'h808080
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [1:0]  mode,
  output logic        hdmi_de,
  output logic        hdmi_hs,
  output logic        hdmi_vs,
  output logic [7:0]  hdmi_r,
  output logic [7:0]  hdmi_g,
  output logic [7:0]  hdmi_b,
  output logic [10:0] pix_x,
  output logic [10:0] pix_y,
  output logic        frame_start,
  output logic        line_start
);

  localparam logic [10:0] H_ACT    = 11'(H_RES);
  localparam logic [10:0] HS_BEG   = 11'(H_RES + H_FP);
  localparam logic [10:0] HS_END   = 11'(H_RES + H_FP + H_SYNC);
  localparam logic [10:0] H_LAST   = 11'(H_RES + H_FP + H_SYNC + H_BP - 1);
  localparam logic [10:0] V_ACT    = 11'(V_RES);
  localparam logic [10:0] VS_BEG   = 11'(V_RES + V_FP);
  localparam logic [10:0] VS_END   = 11'(V_RES + V_FP + V_SYNC);
  localparam logic [10:0] V_LAST   = 11'(V_RES + V_FP + V_SYNC + V_BP - 1);
  localparam logic [10:0] BAR_LAST = 11'(H_RES / 8 - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t      state, state_nx;
  logic [10:0] hc, vc;
  logic [10:0] bar_cnt;
  logic [2:0]  bar_idx;
  logic [7:0]  fcnt;
  logic [1:0]  mode_lat;
  logic        at_end;

  logic        de_d, hs_act, vs_act, fs_d, ls_d;
  logic [23:0] rgb_d;

  assign at_end = (hc == H_LAST) && (vc == V_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (en) state_nx = RUN;
      RUN:  if (at_end && !en) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Bar sub-counter tracks hc so colour bars need no divider.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hc       <= '0;
      vc       <= '0;
      bar_cnt  <= '0;
      bar_idx  <= '0;
      fcnt     <= '0;
      mode_lat <= '0;
    end else if (state == IDLE) begin
      hc      <= '0;
      vc      <= '0;
      bar_cnt <= '0;
      bar_idx <= '0;
      if (en) mode_lat <= mode;
    end else begin
      if (hc == H_LAST) begin
        hc      <= '0;
        bar_cnt <= '0;
        bar_idx <= '0;
        vc      <= (vc == V_LAST) ? 11'd0 : vc + 11'd1;
      end else begin
        hc <= hc + 11'd1;
        if (bar_cnt == BAR_LAST) begin
          bar_cnt <= '0;
          bar_idx <= bar_idx + 3'd1;
        end else begin
          bar_cnt <= bar_cnt + 11'd1;
        end
      end
      if (at_end && en) begin
        fcnt     <= fcnt + 8'd1;
        mode_lat <= mode;
      end
    end
  end

  always_comb begin
    de_d   = 1'b0;
    hs_act = 1'b0;
    vs_act = 1'b0;
    fs_d   = 1'b0;
    ls_d   = 1'b0;
    rgb_d  = 24'h000000;
    if (state == RUN) begin
      de_d   = (hc < H_ACT) && (vc < V_ACT);
      hs_act = (hc >= HS_BEG) && (hc < HS_END);
      vs_act = (vc >= VS_BEG) && (vc < VS_END);
      fs_d   = (hc == 11'd0) && (vc == 11'd0);
      ls_d   = (hc == 11'd0) && (vc < V_ACT);
      if (de_d) begin
        case (mode_lat)
          2'd0: rgb_d = SOLID_RGB;
          2'd1: rgb_d = {{8{~bar_idx[1]}}, {8{~bar_idx[2]}}, {8{~bar_idx[0]}}};
          2'd2: rgb_d = {hc[7:0], vc[7:0], hc[7:0] ^ vc[7:0]};
          default: rgb_d = (hc[CHK_LOG2] ^ vc[CHK_LOG2] ^ fcnt[0]) ? 24'hFFFFFF : 24'h000000;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hdmi_de     <= 1'b0;
      hdmi_hs     <= ~HS_POL;
      hdmi_vs     <= ~VS_POL;
      hdmi_r      <= '0;
      hdmi_g      <= '0;
      hdmi_b      <= '0;
      pix_x       <= '0;
      pix_y       <= '0;
      frame_start <= 1'b0;
      line_start  <= 1'b0;
    end else begin
      hdmi_de     <= de_d;
      hdmi_hs     <= hs_act ? HS_POL : ~HS_POL;
      hdmi_vs     <= vs_act ? VS_POL : ~VS_POL;
      hdmi_r      <= rgb_d[23:16];
      hdmi_g      <= rgb_d[15:8];
      hdmi_b      <= rgb_d[7:0];
      pix_x       <= (state == RUN) ? hc : 11'd0;
      pix_y       <= (state == RUN) ? vc : 11'd0;
      frame_start <= fs_d;
      line_start  <= ls_d;
    end
  end

endmodule

// File: tb/tb_vid_timing_gen.sv
// tb/tb_vid_timing_gen.sv - directed self-checking bench for vid_timing_gen
module tb_vid_timing_gen;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic [1:0]  mode = 2'd0;
  logic        de, hs, vs, fs, ls;
  logic [7:0]  r, g, b;
  logic [10:0] px, py;
  int          total = 0;
  int          passed = 0;

  always #5 clk = ~clk;

  vid_timing_gen dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode),
    .hdmi_de(de), .hdmi_hs(hs), .hdmi_vs(vs),
    .hdmi_r(r), .hdmi_g(g), .hdmi_b(b),
    .pix_x(px), .pix_y(py), .frame_start(fs), .line_start(ls)
  );

  task automatic wait_fs(output bit ok);
    int n;
    ok = 1'b0;
    n = 0;
    while (!ok && n < 8000) begin
      @(negedge clk);
      n++;
      if (fs === 1'b1) ok = 1'b1;
    end
  endtask

  task automatic skip(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic test_reset;
    skip(3);
    total++; if (de !== 1'b0) $display("FAIL reset_de: got %b want 0", de); else passed++;
    total++; if ({hs, vs} !== 2'b11) $display("FAIL reset_sync: got %b want 11", {hs, vs}); else passed++;
    total++; if ({r, g, b} !== 24'h0) $display("FAIL reset_rgb: got %h want 000000", {r, g, b}); else passed++;
    total++; if ({fs, ls, px, py} !== 24'h0) $display("FAIL reset_misc: got %h want 0", {fs, ls, px, py}); else passed++;
    rst = 1'b0;
    skip(3);
    total++; if ({de, fs, hs, vs} !== 4'b0011) $display("FAIL idle_hold: got %b want 0011", {de, fs, hs, vs}); else passed++;
  endtask

  task automatic test_solid;
    bit ok;
    int de_cnt = 0, rgb_bad = 0, blank_bad = 0, hs_first = -1, hs_l0 = 0, hs_cnt = 0;
    int vs_cnt = 0, vs_first = -1, ls_cnt = 0;
    en = 1'b1;
    mode = 2'd0;
    wait_fs(ok);
    total++; if (!ok) $display("FAIL solid_fs: got timeout want frame_start"); else passed++;
    for (int c = 0; c < 6888; c++) begin
      if (de) de_cnt++;
      if (de && {r, g, b} !== 24'h808080) rgb_bad++;
      if (!de && {r, g, b} !== 24'h0) blank_bad++;
      if (hs === 1'b0) begin
        hs_cnt++;
        if (hs_first < 0) hs_first = c;
        if (c < 82) hs_l0++;
      end
      if (vs === 1'b0) begin
        vs_cnt++;
        if (vs_first < 0) vs_first = c;
      end
      if (ls) ls_cnt++;
      @(negedge clk);
    end
    total++; if (de_cnt != 4096) $display("FAIL solid_de_cnt: got %0d want 4096", de_cnt); else passed++;
    total++; if (rgb_bad != 0) $display("FAIL solid_rgb: got %0d bad want 0", rgb_bad); else passed++;
    total++; if (blank_bad != 0) $display("FAIL solid_blank_rgb: got %0d bad want 0", blank_bad); else passed++;
    total++; if (hs_first != 72) $display("FAIL hs_offset: got %0d want 72", hs_first); else passed++;
    total++; if (hs_l0 != 2) $display("FAIL hs_width: got %0d want 2", hs_l0); else passed++;
    total++; if (hs_cnt != 168) $display("FAIL hs_frame_cnt: got %0d want 168", hs_cnt); else passed++;
    total++; if (vs_cnt != 328) $display("FAIL vs_width: got %0d want 328", vs_cnt); else passed++;
    total++; if (vs_first != 5904) $display("FAIL vs_offset: got %0d want 5904", vs_first); else passed++;
    total++; if (ls_cnt != 64) $display("FAIL line_start_cnt: got %0d want 64", ls_cnt); else passed++;
    total++; if (fs !== 1'b1) $display("FAIL frame_period: got fs=%b want 1 at 6888", fs); else passed++;
  endtask

  task automatic test_bars;
    bit ok;
    logic [23:0] bars [8];
    int blank_bad = 0;
    bars = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
             24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
    mode = 2'd1;
    wait_fs(ok);
    total++; if (!ok) $display("FAIL bars_fs: got timeout want frame_start"); else passed++;
    for (int x = 0; x < 82; x++) begin
      if (x < 64) begin
        total++;
        if ({de, r, g, b} !== {1'b1, bars[x/8]})
          $display("FAIL bar_px%0d: got de=%b rgb=%h want de=1 rgb=%h", x, de, {r, g, b}, bars[x/8]);
        else passed++;
      end else if (de || {r, g, b} !== 24'h0) begin
        blank_bad++;
      end
      @(negedge clk);
    end
    total++; if (blank_bad != 0) $display("FAIL bars_blank: got %0d bad want 0", blank_bad); else passed++;
  endtask

  task automatic test_checker;
    bit ok;
    @(negedge clk);
    rst = 1'b1;
    mode = 2'd3;
    en = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    wait_fs(ok);
    total++; if (!ok) $display("FAIL chk_fs0: got timeout want frame_start"); else passed++;
    total++; if ({r, g, b} !== 24'h000000) $display("FAIL chk_f0_p00: got %h want 000000", {r, g, b}); else passed++;
    skip(8);
    total++; if ({px, r, g, b} !== {11'd8, 24'hFFFFFF}) $display("FAIL chk_f0_p80: got x=%0d rgb=%h want x=8 rgb=ffffff", px, {r, g, b}); else passed++;
    wait_fs(ok);
    total++; if (!ok) $display("FAIL chk_fs1: got timeout want frame_start"); else passed++;
    total++; if ({r, g, b} !== 24'hFFFFFF) $display("FAIL chk_f1_p00: got %h want ffffff", {r, g, b}); else passed++;
    skip(8);
    total++; if ({r, g, b} !== 24'h000000) $display("FAIL chk_f1_p80: got %h want 000000", {r, g, b}); else passed++;
  endtask

  task automatic test_mode_change;
    bit ok;
    int bad = 0;
    mode = 2'd0;
    wait_fs(ok);
    total++; if (!ok) $display("FAIL mc_fs: got timeout want frame_start"); else passed++;
    for (int c = 0; c < 6888; c++) begin
      if (c == 820) mode = 2'd2;
      if (de && {r, g, b} !== 24'h808080) bad++;
      @(negedge clk);
    end
    total++; if (bad != 0) $display("FAIL mc_frame_solid: got %0d bad want 0", bad); else passed++;
    total++; if ({fs, r, g, b} !== {1'b1, 24'h000000}) $display("FAIL mc_ramp_p00: got fs=%b rgb=%h want fs=1 rgb=000000", fs, {r, g, b}); else passed++;
    skip(3 * 82 + 5);
    total++; if ({px, py} !== {11'd5, 11'd3}) $display("FAIL mc_xy: got %0d,%0d want 5,3", px, py); else passed++;
    total++; if ({r, g, b} !== 24'h050306) $display("FAIL mc_ramp_p53: got %h want 050306", {r, g, b}); else passed++;
  endtask

  task automatic test_en_drop;
    bit ok;
    int de_cnt = 0, idle_bad = 0;
    wait_fs(ok);
    total++; if (!ok) $display("FAIL ed_fs: got timeout want frame_start"); else passed++;
    for (int c = 0; c < 6888; c++) begin
      if (c == 1640) en = 1'b0;
      if (de) de_cnt++;
      @(negedge clk);
    end
    total++; if (de_cnt != 4096) $display("FAIL ed_full_frame: got %0d want 4096", de_cnt); else passed++;
    total++; if ({de, hs, vs, fs} !== 4'b0110) $display("FAIL ed_idle: got %b want 0110", {de, hs, vs, fs}); else passed++;
    for (int c = 0; c < 100; c++) begin
      if (de || fs || !hs || !vs) idle_bad++;
      @(negedge clk);
    end
    total++; if (idle_bad != 0) $display("FAIL ed_idle_hold: got %0d bad want 0", idle_bad); else passed++;
    en = 1'b1;
    @(negedge clk);
    total++; if (fs !== 1'b0) $display("FAIL ed_fs_early: got %b want 0", fs); else passed++;
    @(negedge clk);
    total++; if (fs !== 1'b1) $display("FAIL ed_fs_2clk: got %b want 1", fs); else passed++;
  endtask

  task automatic test_reset_mid;
    int n = 0, de_cnt = 0, ll = 0;
    skip(30);
    total++; if ({de, px} !== {1'b1, 11'd30}) $display("FAIL rm_pre: got de=%b x=%0d want de=1 x=30", de, px); else passed++;
    rst = 1'b1;
    #1;
    total++; if ({de, r, g, b, hs, vs} !== {25'h0, 2'b11}) $display("FAIL rm_async: got de=%b rgb=%h hs=%b vs=%b want 0/000000/1/1", de, {r, g, b}, hs, vs); else passed++;
    @(negedge clk);
    rst = 1'b0;
    while (fs !== 1'b1 && n < 10) begin
      @(negedge clk);
      n++;
    end
    total++; if (n != 2) $display("FAIL rm_fs_lat: got %0d want 2", n); else passed++;
    do begin
      if (de) de_cnt++;
      @(negedge clk);
      ll++;
    end while (ls !== 1'b1 && ll < 200);
    total++; if (ll != 82) $display("FAIL rm_line_len: got %0d want 82", ll); else passed++;
    total++; if (de_cnt != 64) $display("FAIL rm_line_de: got %0d want 64", de_cnt); else passed++;
  endtask

  initial begin
    test_reset;
    test_solid;
    test_bars;
    test_checker;
    test_mode_change;
    test_en_drop;
    test_reset_mid;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
